// File: rtl/muon_pkg.sv
// Shared state encoding and default timing constants for the muon decay sequencer.
package muon_pkg;

  localparam int unsigned CLK_HZ             = 100_000_000;
  localparam int unsigned WINDOW_CYCLES_DEF  = 2000;
  localparam int unsigned HOLDOFF_CYCLES_DEF = 660;
  localparam int unsigned MIN_GAP_CYCLES_DEF = 2;
  localparam int unsigned TIME_W_DEF         = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WINDOW  = 2'd1,
    REPORT  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/lifetime_timer.sv
// Loadable up-counter shared by the decay window and the holdoff period.
// Terminal compares are registered-count decodes, valid in the same cycle as count_o.
module lifetime_timer
  import muon_pkg::*;
#(
  parameter int unsigned TIME_W         = TIME_W_DEF,
  parameter int unsigned MIN_GAP_CYCLES = MIN_GAP_CYCLES_DEF,
  parameter int unsigned WINDOW_CYCLES  = WINDOW_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [TIME_W-1:0] load_val_i,
  input  logic              inc_i,
  output logic [TIME_W-1:0] count_o,
  output logic              ge_min_o,
  output logic              eq_window_o,
  output logic              eq_holdoff_o
);

  logic [TIME_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (inc_i) begin
      count_d = count_q + TIME_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o      = count_q;
  assign ge_min_o     = (count_q >= TIME_W'(MIN_GAP_CYCLES));
  assign eq_window_o  = (count_q == TIME_W'(WINDOW_CYCLES));
  assign eq_holdoff_o = (count_q == TIME_W'(HOLDOFF_CYCLES));

endmodule

// File: rtl/muon_decay_sequencer.sv
// Start/stop lifetime sequencer: valid one cycle after the stop, held under backpressure
// indefinitely, then HOLDOFF_CYCLES of dead time. Counters exist only with MUON_SEQ_STATS_EN.
module muon_decay_sequencer
  import muon_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES  = WINDOW_CYCLES_DEF,
  parameter int unsigned MIN_GAP_CYCLES = MIN_GAP_CYCLES_DEF,
  parameter int unsigned HOLDOFF_CYCLES = HOLDOFF_CYCLES_DEF,
  parameter int unsigned TIME_W         = TIME_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_pulse,
  input  logic              stop_pulse,
  output logic              arm,
  output logic              busy,
  output logic [TIME_W-1:0] lifetime,
  output logic              lifetime_valid,
  input  logic              lifetime_ready,
  output logic [15:0]       event_count,
  output logic [15:0]       timeout_count
);

  state_t            state_q, state_d;
  logic [TIME_W-1:0] lifetime_q, lifetime_d;
  logic              tmr_load, tmr_inc;
  logic [TIME_W-1:0] elapsed;
  logic              ge_min, eq_window, eq_holdoff;

  lifetime_timer #(
    .TIME_W        (TIME_W),
    .MIN_GAP_CYCLES(MIN_GAP_CYCLES),
    .WINDOW_CYCLES (WINDOW_CYCLES),
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_timer (
    .clk         (clk),
    .rst         (rst),
    .load_i      (tmr_load),
    .load_val_i  (TIME_W'(1)),
    .inc_i       (tmr_inc),
    .count_o     (elapsed),
    .ge_min_o    (ge_min),
    .eq_window_o (eq_window),
    .eq_holdoff_o(eq_holdoff)
  );

  // Loading 1 on every phase entry makes the count equal cycles-since-entry.
  always_comb begin
    state_d    = state_q;
    lifetime_d = lifetime_q;
    tmr_load   = 1'b0;
    tmr_inc    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d  = WINDOW;
          tmr_load = 1'b1;
        end
      end
      WINDOW: begin
        if (stop_pulse && ge_min) begin
          state_d    = REPORT;
          lifetime_d = elapsed;
        end else if (eq_window) begin
          state_d  = HOLDOFF;
          tmr_load = 1'b1;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      REPORT: begin
        if (lifetime_ready) begin
          state_d  = HOLDOFF;
          tmr_load = 1'b1;
        end
      end
      HOLDOFF: begin
        if (eq_holdoff) begin
          state_d = IDLE;
        end else begin
          tmr_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lifetime_q <= '0;
    end else begin
      state_q    <= state_d;
      lifetime_q <= lifetime_d;
    end
  end

  assign arm            = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign lifetime_valid = (state_q == REPORT);
  assign lifetime       = lifetime_q;

`ifdef MUON_SEQ_STATS_EN
  logic [15:0] event_count_q, timeout_count_q;
  logic        accept_w, timeout_w;

  assign accept_w  = (state_q == REPORT) && lifetime_ready;
  assign timeout_w = (state_q == WINDOW) && eq_window && !(stop_pulse && ge_min);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      event_count_q   <= '0;
      timeout_count_q <= '0;
    end else begin
      if (accept_w) event_count_q <= sat_inc16(event_count_q);
      if (timeout_w) timeout_count_q <= sat_inc16(timeout_count_q);
    end
  end

  assign event_count   = event_count_q;
  assign timeout_count = timeout_count_q;
`else
  assign event_count   = 16'd0;
  assign timeout_count = 16'd0;
`endif

endmodule

// File: doc/muon_decay_sequencer.md
# muon_decay_sequencer

Sequences one muon-decay measurement at a time around the coincidence system. A coincidence pulse marks a muon stop and opens a decay window. The block then times cycles until the decay-electron stop pulse and presents the measured lifetime on a valid/ready output. Afterwards it holds off further starts before re-arming. It sits between the coincidence system (start source), the decay-hit discriminator (stop source) and the readout/UART packetiser (lifetime sink).

## Interface
Parameters:
- WINDOW_CYCLES, 2000, maximum start-to-stop interval accepted (20 us at 100 MHz); must be ≥ MIN_GAP_CYCLES and < 2**TIME_W
- MIN_GAP_CYCLES, 2, stops with elapsed time below this are ignored (afterpulse rejection); ≥ 1
- HOLDOFF_CYCLES, 660, dead time after each measurement or timeout; ≥ 1
- TIME_W, 16, lifetime width

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous active-high reset
- start_pulse  in  1  one-cycle coincidence pulse
- stop_pulse  in  1  one-cycle decay-hit pulse
- arm  out  1  high only in IDLE; gates the coincidence path upstream
- busy  out  1  high in WINDOW, REPORT, HOLDOFF
- lifetime  out  TIME_W  measured interval in clk cycles
- lifetime_valid  out  1  lifetime available
- lifetime_ready  in  1  sink accepts lifetime
- event_count  out  16  accepted lifetimes (STATS only)
- timeout_count  out  16  windows expired without stop (STATS only)

## Operation
- States: IDLE, WINDOW, REPORT, HOLDOFF; state register and elapsed/holdoff counter are the only timing state.
- IDLE: the block ignores stop_pulse. When start_pulse is high, it moves to WINDOW and sets elapsed to 1.
- WINDOW:
  - elapsed is the number of cycles since the start cycle.
  - When stop_pulse is high and elapsed ≥ MIN_GAP_CYCLES, the block captures lifetime = elapsed and moves to REPORT.
  - When stop_pulse is high and elapsed < MIN_GAP_CYCLES, the stop is ignored.
  - When elapsed == WINDOW_CYCLES and no stop arrives, the block times out and moves to HOLDOFF.
  - Otherwise elapsed increments by 1.
  - start_pulse is ignored.
- REPORT: lifetime_valid=1 and lifetime is held stable. On lifetime_valid && lifetime_ready, the block moves to HOLDOFF. There is no timeout: backpressure stalls the block indefinitely. start_pulse and stop_pulse are ignored.
- HOLDOFF: the counter runs for exactly HOLDOFF_CYCLES cycles, then the block moves to IDLE.
- Simultaneous start+stop in IDLE: start wins, and the stop is not counted.
- Stop on the elapsed == WINDOW_CYCLES cycle: the stop wins and lifetime = WINDOW_CYCLES.
- lifetime keeps its last captured value outside REPORT.
- Reset mid-operation (any state): the block returns to IDLE immediately, any pending lifetime_valid is dropped, and counters clear.

## Timing
- Reset values: state IDLE, arm=1, busy=0, lifetime_valid=0, lifetime=0, event_count=0, timeout_count=0.
- arm, busy and lifetime_valid are decodes of the registered state, so they have no combinational path from inputs.
- Start sampled at cycle t: arm=0 and busy=1 from t+1.
- Stop sampled at cycle t+n (n ≥ MIN_GAP_CYCLES): lifetime=n and lifetime_valid=1 from t+n+1.
- Handshake accepted at cycle h: HOLDOFF occupies cycles h+1 .. h+HOLDOFF_CYCLES, and arm=1 from h+HOLDOFF_CYCLES+1.
- Timeout: last WINDOW cycle is t+WINDOW_CYCLES, HOLDOFF starts at t+WINDOW_CYCLES+1, and the block re-arms HOLDOFF_CYCLES cycles later.

## Configuration
- Macro MUON_SEQ_STATS_EN.
- Defined: event_count increments on each valid&&ready handshake, and timeout_count increments on each timeout. Both saturate at 16'hFFFF and are cleared only by rst.
- Undefined: the counters are not built, and both ports are tied to 0.
- The ports exist in both builds.

## Structure
- Shared package muon_pkg holds:
  - the state enum (IDLE, WINDOW, REPORT, HOLDOFF)
  - the default constants CLK_HZ=100_000_000, WINDOW_CYCLES_DEF=2000, HOLDOFF_CYCLES_DEF=660
- One sub-module, lifetime_timer: a loadable up-counter with terminal-compare outputs ≥ MIN_GAP and == WINDOW, reused for the HOLDOFF count.
- The FSM and handshake logic stay in muon_decay_sequencer.

## Test plan
- Basic measurement: start at cycle 10, stop at cycle 510, ready=1 → lifetime=500 with valid at cycle 511, arm=1 again at cycle 512+660.
- Afterpulse: with MIN_GAP=2, stops at t+1 and t+40 → first stop ignored, lifetime=40.
- Timeout: start, no stop → HOLDOFF entered at t+2001, lifetime_valid never high, timeout_count=1 (STATS build).
- Backpressure and boundary stop:
  - Stop exactly at elapsed 2000 → lifetime=2000.
  - Hold ready=0 for 100 cycles → valid and lifetime stay stable, extra start/stop pulses are ignored, and the handshake completes once on ready.
- Simultaneous and blocked starts:
  - Start and stop in the same IDLE cycle → WINDOW entered, stop ignored.
  - Start during HOLDOFF → no effect, arm stays 0.
- Reset mid-REPORT: assert rst asynchronously between edges → valid=0, arm=1, counters 0 immediately. The next measurement after release is correct.
